mult_pipe: RTL and testbench

Parametrised, pipelined RV32M multiply functional unit for the execute stage. It replaces the single-cycle combinational multiplier with a NUM_STAGES-deep partial-product pipeline and a valid/ready handshake on both sides. It also supports flush on mispredict. It sits between issue (IS→EX) and complete (EX→IC). It carries dest tag and ROB index alongside each operation.

---
 rtl/mult_pipe_pkg.sv | 35 +++
 rtl/mult_pipe_if.sv | 33 +++
 rtl/mult_pipe_stage.sv | 19 +
 rtl/mult_pipe.sv | 127 ++++++++++++
 tb/tb_mult_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared types for the pipelined RV32M multiply unit: function codes,
// stage packet layout at default widths, and operand-signedness helpers.
package mult_pipe_pkg;

  localparam int XLEN_DEF        = 32;
  localparam int TAG_W_DEF       = 6;
  localparam int ROB_W_DEF       = 5;
  localparam int NUM_MULT_STAGES = 4;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mult_func_e;

  typedef struct packed {
    logic                    valid;
    mult_func_e              func;
    logic [2*XLEN_DEF-1:0]   mcand;
    logic [2*XLEN_DEF-1:0]   mplier;
    logic [2*XLEN_DEF-1:0]   acc;
    logic [TAG_W_DEF-1:0]    tag;
    logic [ROB_W_DEF-1:0]    rob_idx;
  } mult_stage_packet_t;

  function automatic logic opa_is_signed(input mult_func_e f);
    return f != MULHU;
  endfunction

  function automatic logic opb_is_signed(input mult_func_e f);
    return (f == MUL) || (f == MULH);
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Issue-side and complete-side handshake bundle of the multiply unit.
interface mult_pipe_if
  import mult_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  mult_func_e       in_func;
  logic [XLEN-1:0]  in_opa;
  logic [XLEN-1:0]  in_opb;
  logic [TAG_W-1:0] in_tag;
  logic [ROB_W-1:0] in_rob_idx;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic [ROB_W-1:0] out_rob_idx;
  logic             busy;

  modport slave (
    input  flush, in_valid, in_func, in_opa, in_opb, in_tag, in_rob_idx, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_rob_idx, busy
  );

  modport master (
    output flush, in_valid, in_func, in_opa, in_opb, in_tag, in_rob_idx, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_rob_idx, busy
  );
endinterface

// File: rtl/mult_pipe_stage.sv
// One partial-product step: acc_out = acc_in + (mcand << SHIFT) * chunk,
// all arithmetic modulo 2^W with the chunk treated as unsigned.
module mult_pipe_stage #(
  parameter int W     = 64,
  parameter int C     = 16,
  parameter int SHIFT = 0
) (
  input  logic signed [W-1:0] mcand,
  input  logic        [C-1:0] chunk,
  input  logic signed [W-1:0] acc_in,
  output logic signed [W-1:0] acc_out
);
  logic signed [W-1:0] shifted;
  logic signed [W-1:0] chunk_ext;

  assign shifted   = mcand <<< SHIFT;
  assign chunk_ext = $signed(W'(chunk));
  assign acc_out   = acc_in + shifted * chunk_ext;
endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32M multiply unit: NUM_STAGES partial-product steps behind a
// bubble-collapsing valid/ready pipeline with flush on mispredict.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = NUM_MULT_STAGES,
  parameter int TAG_W      = 6,
  parameter int ROB_W      = 5
) (
  input logic        clock,
  input logic        reset,
  mult_pipe_if.slave bus
);
  localparam int W    = 2 * XLEN;
  localparam int C    = W / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;

  function automatic logic signed [W-1:0] extend(input logic [XLEN-1:0] v, input logic sgn);
    return $signed({{XLEN{sgn & v[XLEN-1]}}, v});
  endfunction

  function automatic logic [XLEN-1:0] select_result(input mult_func_e f,
                                                    input logic signed [W-1:0] acc);
    return (f == MUL) ? acc[XLEN-1:0] : acc[W-1:XLEN];
  endfunction

  logic [NUM_STAGES-1:0]          vld_p;
  mult_func_e                     func_p   [NUM_STAGES];
  logic signed [W-1:0]            mcand_p  [NUM_STAGES];
  logic        [W-1:0]            mplier_p [NUM_STAGES];
  logic signed [W-1:0]            acc_p    [NUM_STAGES];
  logic [TAG_W-1:0]               tag_p    [NUM_STAGES];
  logic [ROB_W-1:0]               rob_p    [NUM_STAGES];

  logic [NUM_STAGES-1:0]          adv;
  logic [NUM_STAGES-1:0]          vld_in;
  mult_func_e                     func_in  [NUM_STAGES];
  logic signed [W-1:0]            mcand_in [NUM_STAGES];
  logic        [W-1:0]            mpl_in   [NUM_STAGES];
  logic signed [W-1:0]            acc_in   [NUM_STAGES];
  logic [TAG_W-1:0]               tag_in   [NUM_STAGES];
  logic [ROB_W-1:0]               rob_in   [NUM_STAGES];
  logic [NUM_STAGES-1:0][W-1:0]   acc_sum;

  // A stage may move when it is empty or its successor is moving.
  always_comb begin
    adv       = '0;
    adv[LAST] = !vld_p[LAST] || bus.out_ready;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld_p[k] || adv[k+1];
    end
  end

  assign bus.in_ready = adv[0] && !bus.flush;

  // The multiplier is shifted right by C as it moves, so each stage
  // always consumes the low C bits of what it receives.
  always_comb begin
    vld_in[0]   = bus.in_valid && bus.in_ready;
    func_in[0]  = bus.in_func;
    mcand_in[0] = extend(bus.in_opa, opa_is_signed(bus.in_func));
    mpl_in[0]   = extend(bus.in_opb, opb_is_signed(bus.in_func));
    acc_in[0]   = '0;
    tag_in[0]   = bus.in_tag;
    rob_in[0]   = bus.in_rob_idx;
    for (int k = 1; k < NUM_STAGES; k++) begin
      vld_in[k]   = vld_p[k-1];
      func_in[k]  = func_p[k-1];
      mcand_in[k] = mcand_p[k-1];
      mpl_in[k]   = mplier_p[k-1];
      acc_in[k]   = acc_p[k-1];
      tag_in[k]   = tag_p[k-1];
      rob_in[k]   = rob_p[k-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mult_pipe_stage #(
      .W     (W),
      .C     (C),
      .SHIFT (k * C)
    ) u_stage (
      .mcand   (mcand_in[k]),
      .chunk   (mpl_in[k][C-1:0]),
      .acc_in  (acc_in[k]),
      .acc_out (acc_sum[k])
    );
  end

  // Stage boundary registers p0 .. p(NUM_STAGES-1)
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        func_p[k]   <= MUL;
        mcand_p[k]  <= '0;
        mplier_p[k] <= '0;
        acc_p[k]    <= '0;
        tag_p[k]    <= '0;
        rob_p[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (bus.flush) begin
          vld_p[k] <= 1'b0;
        end else if (adv[k]) begin
          vld_p[k] <= vld_in[k];
        end
        if (adv[k] && vld_in[k] && !bus.flush) begin
          func_p[k]   <= func_in[k];
          mcand_p[k]  <= mcand_in[k];
          mplier_p[k] <= mpl_in[k] >> C;
          acc_p[k]    <= acc_sum[k];
          tag_p[k]    <= tag_in[k];
          rob_p[k]    <= rob_in[k];
        end
      end
    end
  end

  assign bus.out_valid   = vld_p[LAST];
  assign bus.out_result  = select_result(func_p[LAST], acc_p[LAST]);
  assign bus.out_tag     = tag_p[LAST];
  assign bus.out_rob_idx = rob_p[LAST];
  assign bus.busy        = |vld_p;
endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe with a scoreboard of expected completions.
module tb_mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int NS = NUM_MULT_STAGES
);
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int ROB_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W), .ROB_W(ROB_W)) bus ();

  mult_pipe #(
    .XLEN       (XLEN),
    .NUM_STAGES (NS),
    .TAG_W      (TAG_W),
    .ROB_W      (ROB_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  function automatic logic [XLEN-1:0] model(input mult_func_e f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint xa, xb;
    logic [63:0] p;
    xa = (f == MULHU) ? longint'({32'b0, a}) : longint'($signed(a));
    xb = (f == MUL || f == MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(xa * xb);
    return (f == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready) begin
      xfers++;
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL out_unexpected: observed result %0h with empty scoreboard, expected no output",
               bus.out_result);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 64'({bus.out_result, bus.out_tag, bus.out_rob_idx}),
              64'({e.result, e.tag, e.rob}));
      end
    end
    if (!reset || bus.flush) begin
      sb.delete();
    end else if (bus.in_valid && bus.in_ready) begin
      sb.push_back('{result: model(bus.in_func, bus.in_opa, bus.in_opb),
                     tag: bus.in_tag, rob: bus.in_rob_idx});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input mult_func_e f, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input logic [ROB_W-1:0] r);
    bus.in_valid   = 1'b1;
    bus.in_func    = f;
    bus.in_opa     = a;
    bus.in_opb     = b;
    bus.in_tag     = t;
    bus.in_rob_idx = r;
  endtask

  task automatic check_idle(input string name);
    check({name, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({name, "_out_result"}, 64'(bus.out_result), 64'(0));
    check({name, "_out_tag"}, 64'(bus.out_tag), 64'(0));
    check({name, "_out_rob"}, 64'(bus.out_rob_idx), 64'(0));
    check({name, "_busy"}, 64'(bus.busy), 64'(0));
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'(1));
  endtask

  task automatic run_one(input string name, input mult_func_e f, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t,
                         input logic [ROB_W-1:0] r, input logic [31:0] exp_res);
    int lat;
    drive(f, a, b, t, r);
    #1;
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(NS));
    check({name, "_result"}, 64'({bus.out_result, bus.out_tag, bus.out_rob_idx}),
          64'({exp_res, t, r}));
    tick();
  endtask

  initial begin
    int   x0;
    int   sent;
    int   n;
    logic took;
    logic [63:0] hold;

    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_func    = MUL;
    bus.in_opa     = '0;
    bus.in_opb     = '0;
    bus.in_tag     = '0;
    bus.in_rob_idx = '0;
    bus.out_ready  = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    check_idle("reset");

    run_one("mul_neg", MUL, 32'd7, 32'hFFFF_FFFD, 6'd5, 5'd3, 32'hFFFF_FFEB);
    run_one("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 6'd11, 5'd4, 32'h4000_0000);
    run_one("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd12, 5'd5, 32'hFFFF_FFFF);
    run_one("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13, 5'd6, 32'hFFFF_FFFE);

    for (int j = 0; j < 8 + NS; j++) begin
      if (j < 8) begin
        drive(MUL, 32'(j), 32'(j + 1), 6'(10 + j), 5'(j));
        #1;
        check("b2b_in_ready", 64'(bus.in_ready), 64'(1));
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      check("b2b_out_valid", 64'(bus.out_valid), 64'(j >= NS - 1 && j <= NS + 6));
    end
    check("b2b_drained", 64'(sb.size()), 64'(0));

    bus.out_ready = 1'b0;
    x0   = xfers;
    sent = 0;
    for (int c = 0; c < NS + 3; c++) begin
      drive(MUL, 32'(100 + sent), 32'd3, 6'(20 + sent), 5'(sent));
      #1;
      check("stall_in_ready", 64'(bus.in_ready), 64'(c < NS));
      took = bus.in_ready;
      tick();
      if (took) sent++;
    end
    check("stall_accepts", 64'(sent), 64'(NS));
    check("stall_out_valid", 64'(bus.out_valid), 64'(1));
    check("stall_first", 64'({bus.out_result, bus.out_tag, bus.out_rob_idx}),
          64'({32'd300, 6'd20, 5'd0}));
    hold = 64'({bus.out_result, bus.out_tag, bus.out_rob_idx});
    repeat (2) tick();
    check("stall_hold_valid", 64'(bus.out_valid), 64'(1));
    check("stall_hold_data", 64'({bus.out_result, bus.out_tag, bus.out_rob_idx}), hold);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check("stall_drain_count", 64'(xfers - x0), 64'(NS));
    check("stall_drain_empty", 64'(sb.size()), 64'(0));

    for (int i = 0; i < 3; i++) begin
      drive(MULHU, 32'hFFFF_0000 + 32'(i), 32'h10, 6'(30 + i), 5'(8 + i));
      tick();
    end
    drive(MUL, 32'd5, 32'd5, 6'd40, 5'd12);
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_busy", 64'(bus.busy), 64'(0));
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    x0 = xfers;
    repeat (NS + 1) tick();
    check("flush_no_out", 64'(xfers - x0), 64'(0));
    run_one("post_flush", MUL, 32'd5, 32'd6, 6'd7, 5'd1, 32'd30);

    drive(MULH, 32'h1234_5678, 32'h9ABC_DEF0, 6'd50, 5'd20);
    tick();
    drive(MUL, 32'd9, 32'd9, 6'd51, 5'd21);
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("rst_mid");
    x0 = xfers;
    repeat (NS + 1) tick();
    check("rst_no_out", 64'(xfers - x0), 64'(0));
    run_one("post_reset", MULHSU, 32'hFFFF_FFFE, 32'd3, 6'd9, 5'd2, 32'hFFFF_FFFF);

    check("final_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
